// File: rtl/bram_rd_arbiter_pkg.sv
// Shared definitions for the two-requester BRAM read arbiter: FSM encoding,
// requester index constants and default bus widths.
package bram_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid/owner-tag shift register matching the BRAM read latency, so each
// returning word is steered to the requester that issued it.
module rd_latency_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner,
  output logic any_valid
);

  logic [RD_LATENCY-1:0] valid_q, valid_d;
  logic [RD_LATENCY-1:0] owner_q, owner_d;

  // Next-stage values: stage 0 takes the new beat, later stages shift.
  always_comb begin
    valid_d    = '0;
    owner_d    = '0;
    valid_d[0] = in_valid;
    owner_d[0] = in_owner;
    for (int i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  // Pipe registers; reset discards every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign out_valid = valid_q[RD_LATENCY-1];
  assign out_owner = owner_q[RD_LATENCY-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between two burst requesters,
// with a burst cap that forces hand-off when the other side is waiting.
module bram_rd_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  last0,
  input  logic                  last1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_e                state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic [CNT_W-1:0]      burst_q, burst_d, burst_inc_s;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  acc0_s, acc1_s, accept_s;
  logic                  own_req_s, own_last_s, oth_req_s, leave_s;
  logic                  pipe_valid_s, pipe_owner_s, pipe_busy_s;

  assign acc0_s   = req0 & (state_q == ST_OWN0);
  assign acc1_s   = req1 & (state_q == ST_OWN1);
  assign accept_s = acc0_s | acc1_s;
  assign bram_en  = accept_s;
  assign addr_d   = bram_addr;

  // Address mux: follows the accepted requester, otherwise holds the last beat.
  always_comb begin
    bram_addr = addr_q;
    if (acc0_s) begin
      bram_addr = addr0;
    end else if (acc1_s) begin
      bram_addr = addr1;
    end else begin
      bram_addr = addr_q;
    end
  end

  // Next-state, round-robin and burst-cap decisions.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    own_req_s    = 1'b0;
    own_last_s   = 1'b0;
    oth_req_s    = 1'b0;
    leave_s      = 1'b0;
    if (accept_s && (burst_q != CNT_MAX)) begin
      burst_inc_s = burst_q + CNT_W'(1);
    end else begin
      burst_inc_s = burst_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = (last_owner_q == REQ1) ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0: begin
        own_req_s  = req0;
        own_last_s = last0;
        oth_req_s  = req1;
      end
      ST_OWN1: begin
        own_req_s  = req1;
        own_last_s = last1;
        oth_req_s  = req0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // The cap only bites once the other side is actually waiting.
    if ((state_q == ST_OWN0) || (state_q == ST_OWN1)) begin
      leave_s = (accept_s && own_last_s) || !own_req_s ||
                ((burst_inc_s == CNT_MAX) && oth_req_s);
    end else begin
      leave_s = 1'b0;
    end
    if (leave_s) begin
      if (oth_req_s) begin
        state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_d;
    end
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      last_owner_d = (state_d == ST_OWN1) ? REQ1 : REQ0;
    end else begin
      last_owner_d = last_owner_q;
    end
    if (state_d != state_q) begin
      burst_d = '0;
    end else begin
      burst_d = burst_inc_s;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= REQ1;
      burst_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      addr_q       <= addr_d;
    end
  end

  rd_latency_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept_s),
    .in_owner (acc1_s ? REQ1 : REQ0),
    .out_valid(pipe_valid_s),
    .out_owner(pipe_owner_s),
    .any_valid(pipe_busy_s)
  );

  assign gnt0    = (state_q == ST_OWN0);
  assign gnt1    = (state_q == ST_OWN1);
  assign rvalid0 = pipe_valid_s & (pipe_owner_s == REQ0);
  assign rvalid1 = pipe_valid_s & (pipe_owner_s == REQ1);
  assign rdata   = bram_dout;
  assign busy    = (state_q != ST_IDLE) | pipe_busy_s;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Randomized bench for bram_rd_arbiter against a cycle-level ownership model
// with a pending-read queue and a behavioural BRAM.
module tb_bram_rd_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, last0, last1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1, bram_en, busy;
  logic [DW-1:0] rdata, bram_dout;
  logic [AW-1:0] bram_addr;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] bstage [0:1];

  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  int            owner;
  int            last_owner;
  int            beats;
  logic [AW-1:0] last_addr;
  int            cyc;
  int            checks = 0;
  int            errors = 0;
  bit            exp_acc;
  bit            prev_acc;
  int            last_mode;

  bram_rd_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LATENCY(LAT),
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .last0    (last0),
    .last1    (last1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .bram_en  (bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM with LAT-cycle read latency; garbage when not enabled.
  always @(posedge clk) begin
    bstage[0] <= bram_en ? mem[bram_addr] : DW'($urandom);
    bstage[1] <= bstage[0];
  end
  assign bram_dout = bstage[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit req_of(input int k);
    return (k == 0) ? req0 : req1;
  endfunction

  function automatic bit last_of(input int k);
    return (k == 0) ? last0 : last1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int k);
    return (k == 0) ? addr0 : addr1;
  endfunction

  task automatic model_reset();
    owner      = -1;
    last_owner = 1;
    beats      = 0;
    last_addr  = '0;
    pend.delete();
  endtask

  task automatic compare_all();
    bit            rv0, rv1;
    logic [AW-1:0] ea;
    exp_acc = (owner >= 0) && req_of(owner);
    ea      = exp_acc ? addr_of(owner) : last_addr;
    rv0     = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].who == 0);
    rv1     = (pend.size() > 0) && (pend[0].due == cyc) && (pend[0].who == 1);
    check_eq("gnt0", 32'(gnt0), 32'(owner == 0));
    check_eq("gnt1", 32'(gnt1), 32'(owner == 1));
    check_eq("bram_en", 32'(bram_en), 32'(exp_acc));
    check_eq("bram_addr", 32'(bram_addr), 32'(ea));
    check_eq("rvalid0", 32'(rvalid0), 32'(rv0));
    check_eq("rvalid1", 32'(rvalid1), 32'(rv1));
    check_eq("busy", 32'(busy), 32'((owner >= 0) || (pend.size() > 0)));
    if (rv0 || rv1) begin
      check_eq("rdata", 32'(rdata), 32'(pend[0].data));
    end
  endtask

  task automatic step_model();
    int  oth;
    bit  leave;
    if ((pend.size() > 0) && (pend[0].due == cyc)) pend.pop_front();
    if (exp_acc) begin
      pend.push_back('{cyc + LAT, owner, mem[addr_of(owner)]});
      last_addr = addr_of(owner);
      if (beats < MAXB) beats++;
    end
    if (owner < 0) begin
      if (req0 && req1) owner = 1 - last_owner;
      else if (req0) owner = 0;
      else if (req1) owner = 1;
      if (owner >= 0) begin
        last_owner = owner;
        beats      = 0;
      end
    end else begin
      oth   = 1 - owner;
      leave = (exp_acc && last_of(owner)) || !req_of(owner) || ((beats >= MAXB) && req_of(oth));
      if (leave) begin
        beats = 0;
        if (req_of(oth)) begin
          owner      = oth;
          last_owner = oth;
        end else begin
          owner = -1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    last0 = 1'b0;
    last1 = 1'b0;
    addr0 = '0;
    addr1 = '0;
    cyc   = 0;
    prev_acc  = 1'b0;
    last_mode = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      compare_all();
      cyc++;
    end
    // Both requests rise together right after reset to exercise the first tie.
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    compare_all();
    step_model();
    prev_acc = exp_acc;
    cyc++;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ((c % 200) == 0) last_mode = $urandom_range(0, 2);
      if ((c >= 1500) && (c < 1600) && prev_acc && !rst) begin
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        model_reset();
        #1;
        compare_all();
        prev_acc = 1'b0;
        c        = 1600;
        cyc++;
        continue;
      end
      rst = 1'b0;
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      last0 = (last_mode == 0) ? 1'b0 : ($urandom_range(0, 3 * last_mode) == 0);
      last1 = (last_mode == 0) ? 1'b0 : ($urandom_range(0, 3 * last_mode) == 0);
      #1;
      compare_all();
      step_model();
      prev_acc = exp_acc;
      cyc++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_rd_arbiter.md
BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16; BRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8; BRAM read data width.
REQ-003 Parameter RD_LATENCY, default 1; BRAM read latency in cycles, legal range 1..2.
REQ-004 Parameter MAX_BURST, default 256; beats one owner may take before a forced hand-off when the other requester waits.
REQ-005 Ports: one clock; reset is asynchronous and active-high. The ports are named clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req0 / req1  in  1 each  read request from requester 0 (downsampler fetch) and requester 1 (display/readback).
REQ-009 addr0 / addr1  in  ADDR_WIDTH each  read address, valid while the matching req is high.
REQ-010 last0 / last1  in  1 each  current beat is the final beat of the burst.
REQ-011 gnt0 / gnt1  out  1 each  requester owns the port; a beat is accepted in any cycle where reqk and gntk are both high.
REQ-012 rvalid0 / rvalid1  out  1 each  rdata holds the data for an accepted beat of that requester.
REQ-013 rdata  out  DATA_WIDTH  read data, shared by both requesters.
REQ-014 bram_en  out  1  BRAM read enable.
REQ-015 bram_addr  out  ADDR_WIDTH  BRAM read address.
REQ-016 bram_dout  in  DATA_WIDTH  BRAM read data.
REQ-017 busy  out  1  a grant is held or a read is still in flight.

Function
REQ-018 The FSM SHALL have states IDLE, OWN0 and OWN1; gntk SHALL be high only in OWNk, and at most one grant SHALL be high.
REQ-019 In IDLE with only reqk high, the FSM SHALL move to OWNk on the next edge; a grant is never given in the same cycle as the first request.
REQ-020 In IDLE with both requests high, the FSM SHALL grant the requester that was not granted last (round-robin); the last-owner register resets to 1, so requester 0 wins the first tie.
REQ-021 On an accepted beat, bram_en SHALL be 1 and bram_addr SHALL equal addrk combinationally in the same cycle; otherwise bram_en SHALL be 0 and bram_addr SHALL hold its last value.
REQ-022 rvalidk SHALL assert exactly RD_LATENCY cycles after the accepted beat, with rdata = bram_dout in that cycle. Beat order SHALL be preserved, and one rvalid pulse SHALL be produced per accepted beat.
REQ-023 The FSM SHALL leave OWNk after any one of the following:
- an accepted beat with lastk high;
- reqk low while granted, with no beat accepted;
- the burst counter reaching MAX_BURST beats while the other requester is requesting.
REQ-024 On leaving OWNk, the FSM SHALL go directly to OWN(other) if the other request is high (zero-bubble hand-off), and to IDLE otherwise.
REQ-025 The burst counter SHALL be $clog2(MAX_BURST+1) bits wide, reset to 0 on every grant change, and saturate at MAX_BURST with no wrap.
REQ-026 When MAX_BURST is reached and the other requester is idle, the owner SHALL keep the grant and the counter SHALL stay saturated.
REQ-027 In-flight reads SHALL complete to their original requester after a grant change; the owner tag travels with the valid bit through the latency pipe.
REQ-028 busy SHALL be high when state != IDLE or any latency-pipe stage is valid.

Reset
REQ-029 While rst is high, the following SHALL be held: state = IDLE, gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, bram_en = 0, bram_addr = 0, burst counter = 0, last owner = 1, all pipe stages invalid, busy = 0.
REQ-030 Reset asserted mid-burst SHALL discard in-flight reads; no rvalid SHALL appear after reset deassertion for beats accepted before it.
REQ-031 rdata is not reset; it follows bram_dout.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), the requester index constants and the default ADDR_WIDTH/DATA_WIDTH.
REQ-033 The valid/owner-tag shift register SHALL be a sub-module named rd_latency_pipe, parameterised by RD_LATENCY.
REQ-034 The top level SHALL contain the FSM, the burst counter and the address multiplexer.

Verification
REQ-035 Single requester: req0 with addresses 0..3 and last0 on address 3, RD_LATENCY=1 -> gnt0 one cycle after req0; bram_addr 0,1,2,3 on consecutive cycles; 4 rvalid0 pulses one cycle later; state IDLE afterwards.
REQ-036 Tie: req0 and req1 rise together just after reset -> OWN0 first; after last0, hand-off to OWN1 with no idle cycle; the next tie goes to requester 0.
REQ-037 Starvation: MAX_BURST=4, req0 held with last0 never asserted, req1 waiting -> gnt0 drops after 4 accepted beats and gnt1 rises on the next cycle.
REQ-038 In-flight hand-off: RD_LATENCY=2, last0 accepted at cycle N, OWN1 beat at N+1 -> rvalid0 at N+2 and rvalid1 at N+3, never swapped.
REQ-039 Reset mid-burst: rst pulsed one cycle after an accepted beat -> all outputs 0 immediately, and no rvalid for that beat afterwards.
REQ-040 Withdrawn request: req1 granted, then dropped before any beat -> FSM returns to IDLE; bram_en stays 0 throughout.
